// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and colour types for the video path.
// Other tick-driven blocks import this to stay in step with the sync generator.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int RGB_W = 12;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam rgb_t BLACK = '0;

    function automatic logic in_window(
        input cnt_t pos,
        input cnt_t lo,
        input cnt_t hi
    );
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running divider producing a registered one-clk tick every CLK_DIV clks.
// First tick lands CLK_DIV clks after reset release.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] count;
    logic         wrap;

    assign wrap = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            p_tick <= 1'b0;
        end else begin
            count  <= wrap ? '0 : count + 1'b1;
            p_tick <= wrap;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel counters, sync decode and aligned output stage.
// Sync and colour lag x/y by exactly one pixel tick.
module vga_sync_gen #(
    parameter int   CLK_DIV     = 4,
    parameter int   H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK      = vga_timing_pkg::H_BACK,
    parameter int   V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [vga_timing_pkg::RGB_W-1:0] rgb_in,
    output logic [vga_timing_pkg::CNT_W-1:0] x,
    output logic [vga_timing_pkg::CNT_W-1:0] y,
    output logic                             video_on,
    output logic                             p_tick,
    output logic                             frame_tick,
    output logic                             hsync,
    output logic                             vsync,
    output logic [vga_timing_pkg::RGB_W-1:0] rgb
);

    import vga_timing_pkg::*;

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_LAST   = CNT_W'(H_TOT - 1);
    localparam cnt_t V_LAST   = CNT_W'(V_TOT - 1);
    localparam cnt_t H_VIS    = CNT_W'(H_DISPLAY);
    localparam cnt_t V_VIS    = CNT_W'(V_DISPLAY);
    localparam cnt_t V_PRE    = CNT_W'(V_DISPLAY - 1);
    localparam cnt_t HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam cnt_t HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam cnt_t VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    cnt_t h_count;
    cnt_t v_count;
    logic h_end;
    logic v_end;
    logic h_sync_raw;
    logic v_sync_raw;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    assign h_end = (h_count == H_LAST);
    assign v_end = (v_count == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                h_count <= '0;
                v_count <= v_end ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    assign x        = h_count;
    assign y        = v_count;
    assign video_on = (h_count < H_VIS) && (v_count < V_VIS);

    assign h_sync_raw = in_window(h_count, HS_START, HS_END);
    assign v_sync_raw = in_window(v_count, VS_START, VS_END);

    // Entry into vertical blank is the last pixel of the last visible line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= p_tick && h_end && (v_count == V_PRE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
            rgb   <= BLACK;
        end else if (p_tick) begin
            hsync <= h_sync_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= v_sync_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            rgb   <= video_on ? rgb_in : BLACK;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a scaled-down raster so whole frames fit in a short run.
// Expected sync/colour is queued at each pixel tick and popped when the output stage updates.
module tb_vga_sync_gen;

    localparam int CD = 4;
    localparam int HD = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 4;
    localparam int VD = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = 12'h5A3;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        p_tick;
    logic        frame_tick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    vga_sync_gen #(
        .CLK_DIV    (CD),
        .H_DISPLAY  (HD),
        .H_FRONT    (HF),
        .H_SYNC     (HS),
        .H_BACK     (HB),
        .V_DISPLAY  (VD),
        .V_FRONT    (VF),
        .V_SYNC     (VS),
        .V_BACK     (VB),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rgb_in    (rgb_in),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .p_tick    (p_tick),
        .frame_tick(frame_tick),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   k;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rgb_mode = 2;
    int   mx;
    int   my;
    logic m_pt;
    logic m_new;
    logic m_ft;

    // Reference timing derived purely from clocks elapsed since reset release.
    task automatic model_eval();
        int n;
        n     = (k >= 1) ? (k - 1) / CD : 0;
        mx    = n % HT;
        my    = (n / HT) % VT;
        m_pt  = (k > 0) && (k % CD == 0);
        m_new = (k > CD) && ((k - 1) % CD == 0);
        m_ft  = m_new && (n % FT == VD * HT);
    endtask

    task automatic clear_model();
        k = 0;
        sb.delete();
        cur = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
        model_eval();
    endtask

    task automatic step();
        exp_t e;
        logic von;
        @(posedge clk);
        k++;
        @(negedge clk);
        if (rgb_mode == 0) rgb_in = 12'hFFF;
        else if (rgb_mode == 1) rgb_in = 12'($urandom_range(0, 4095));
        model_eval();
        if (m_new) begin
            if (sb.size() > 0) cur = sb.pop_front();
            else cur = 'x;
        end
        if (m_pt) begin
            von   = (mx < HD) && (my < VD);
            e.hs  = !((mx >= HD + HF) && (mx <= HD + HF + HS - 1));
            e.vs  = !((my >= VD + VF) && (my <= VD + VF + VS - 1));
            e.rgb = von ? rgb_in : 12'h000;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        int first;
        first = -1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 7;
        if (x !== 10'd0) begin n_bad++; $display("FAIL rst_x: got %0d want 0", x); end
        if (y !== 10'd0) begin n_bad++; $display("FAIL rst_y: got %0d want 0", y); end
        if (rgb !== 12'h000) begin n_bad++; $display("FAIL rst_rgb: got %h want 000", rgb); end
        if (hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync: got %b want 1", hsync); end
        if (vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync: got %b want 1", vsync); end
        if (p_tick !== 1'b0) begin n_bad++; $display("FAIL rst_ptick: got %b want 0", p_tick); end
        if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_ftick: got %b want 0", frame_tick); end
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp += 2;
            if (p_tick !== m_pt) begin
                n_bad++;
                $display("FAIL ptick_cadence k=%0d: got %b want %b", k, p_tick, m_pt);
            end
            if (x !== 10'(mx)) begin n_bad++; $display("FAIL early_x k=%0d: got %0d want %0d", k, x, mx); end
            if (p_tick === 1'b1 && first < 0) first = k;
        end
        n_cmp++;
        if (first !== CD) begin n_bad++; $display("FAIL first_ptick: got clk %0d want clk %0d", first, CD); end
    endtask

    task automatic test_line_wrap();
        bit found;
        found = 0;
        rgb_mode = 1;
        for (int i = 0; i < 2 * FT * CD; i++) begin
            step();
            n_cmp += 4;
            if (x !== 10'(mx)) begin n_bad++; $display("FAIL wrap_x: got %0d want %0d", x, mx); end
            if (y !== 10'(my)) begin n_bad++; $display("FAIL wrap_y: got %0d want %0d", y, my); end
            if (x >= 10'(HT)) begin n_bad++; $display("FAIL wrap_xmax: got %0d want <%0d", x, HT); end
            if ({hsync, vsync, rgb} !== cur) begin
                n_bad++;
                $display("FAIL wrap_out: got %b%b %h want %b%b %h", hsync, vsync, rgb, cur.hs, cur.vs, cur.rgb);
            end
            if (m_pt && mx == HT - 1 && my == 10) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL wrap_timeout: got none want h=%0d v=10", HT - 1); end
        step();
        n_cmp += 2;
        if (x !== 10'd0) begin n_bad++; $display("FAIL wrap_x0: got %0d want 0", x); end
        if (y !== 10'd11) begin n_bad++; $display("FAIL wrap_y11: got %0d want 11", y); end
    endtask

    task automatic test_hsync();
        int cnt, first, last, pix;
        bit found;
        cnt = 0; first = -1; last = -1; pix = 0; found = 0;
        for (int i = 0; i < HT * CD * 2; i++) begin
            step();
            if (m_new && mx == 0) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL hs_timeout: got none want line start"); end
        while (pix < HT) begin
            step();
            if (m_pt) begin
                pix++;
                if (hsync === 1'b0) begin
                    cnt++;
                    if (first < 0) first = mx;
                    last = mx;
                end
            end
        end
        n_cmp += 3;
        if (cnt !== HS) begin n_bad++; $display("FAIL hs_width: got %0d want %0d", cnt, HS); end
        if (first !== HD + HF + 1) begin n_bad++; $display("FAIL hs_fall: got %0d want %0d", first, HD + HF + 1); end
        if (last !== HD + HF + HS) begin n_bad++; $display("FAIL hs_rise: got %0d want %0d", last, HD + HF + HS); end
    endtask

    task automatic test_vsync_frame();
        int vcnt, fcnt;
        vcnt = 0; fcnt = 0;
        rgb_mode = 1;
        for (int i = 0; i < FT * CD; i++) begin
            step();
            if (m_pt && vsync === 1'b0) vcnt++;
            n_cmp += 2;
            if (frame_tick !== m_ft) begin
                n_bad++;
                $display("FAIL ftick: got %b want %b at x=%0d y=%0d", frame_tick, m_ft, mx, my);
            end
            if ({hsync, vsync, rgb} !== cur) begin
                n_bad++;
                $display("FAIL frame_out: got %b%b %h want %b%b %h", hsync, vsync, rgb, cur.hs, cur.vs, cur.rgb);
            end
            if (frame_tick === 1'b1) begin
                fcnt++;
                n_cmp++;
                if (x !== 10'd0 || y !== 10'(VD)) begin
                    n_bad++;
                    $display("FAIL ftick_pos: got %0d,%0d want 0,%0d", x, y, VD);
                end
            end
        end
        n_cmp += 2;
        if (vcnt !== VS * HT) begin n_bad++; $display("FAIL vs_width: got %0d want %0d", vcnt, VS * HT); end
        if (fcnt !== 1) begin n_bad++; $display("FAIL ftick_count: got %0d want 1", fcnt); end
    endtask

    task automatic test_blanking();
        rgb_mode = 0;
        for (int i = 0; i < FT * CD; i++) begin
            step();
            n_cmp++;
            if (rgb !== cur.rgb) begin n_bad++; $display("FAIL blank_rgb: got %h want %h", rgb, cur.rgb); end
            if (m_new && mx == HD && my < VD) begin
                n_cmp++;
                if (rgb !== 12'hFFF) begin n_bad++; $display("FAIL blank_last: got %h want FFF", rgb); end
            end
            if (m_new && mx == HD + 1 && my < VD) begin
                n_cmp++;
                if (rgb !== 12'h000) begin n_bad++; $display("FAIL blank_edge: got %h want 000", rgb); end
            end
            if (my >= VD) begin
                n_cmp++;
                if (rgb !== 12'h000) begin n_bad++; $display("FAIL blank_vert y=%0d: got %h want 000", my, rgb); end
            end
        end
    endtask

    task automatic test_rgb_sample();
        logic [11:0] prev;
        logic        prev_pt;
        rgb_mode = 1;
        prev = rgb; prev_pt = m_pt;
        for (int i = 0; i < 3 * HT * CD; i++) begin
            step();
            n_cmp++;
            if (rgb !== cur.rgb) begin n_bad++; $display("FAIL sample_rgb: got %h want %h", rgb, cur.rgb); end
            if (!prev_pt) begin
                n_cmp++;
                if (rgb !== prev) begin n_bad++; $display("FAIL rgb_hold: got %h want %h", rgb, prev); end
            end
            prev = rgb; prev_pt = m_pt;
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        int fk;
        found = 0; fk = -1;
        rgb_mode = 1;
        for (int i = 0; i < (FT + 2) * CD; i++) begin
            step();
            if (m_new && mx == HD + HF + 2 && my == 7) begin found = 1; break; end
        end
        n_cmp += 2;
        if (!found) begin n_bad++; $display("FAIL mid_timeout: got none want x=%0d y=7", HD + HF + 2); end
        if (hsync !== 1'b0) begin n_bad++; $display("FAIL mid_pre_hs: got %b want 0", hsync); end
        #2 reset = 1'b1;
        #1;
        n_cmp += 6;
        if (x !== 10'd0) begin n_bad++; $display("FAIL mid_x: got %0d want 0", x); end
        if (y !== 10'd0) begin n_bad++; $display("FAIL mid_y: got %0d want 0", y); end
        if (hsync !== 1'b1) begin n_bad++; $display("FAIL mid_hs: got %b want 1", hsync); end
        if (vsync !== 1'b1) begin n_bad++; $display("FAIL mid_vs: got %b want 1", vsync); end
        if (rgb !== 12'h000) begin n_bad++; $display("FAIL mid_rgb: got %h want 000", rgb); end
        if (p_tick !== 1'b0) begin n_bad++; $display("FAIL mid_pt: got %b want 0", p_tick); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < (VD * HT + 4) * CD; i++) begin
            step();
            n_cmp += 2;
            if ({hsync, vsync, rgb} !== cur) begin
                n_bad++;
                $display("FAIL restart_out: got %b%b %h want %b%b %h", hsync, vsync, rgb, cur.hs, cur.vs, cur.rgb);
            end
            if (frame_tick !== m_ft) begin n_bad++; $display("FAIL restart_ft: got %b want %b", frame_tick, m_ft); end
            if (frame_tick === 1'b1) begin fk = k; break; end
        end
        n_cmp += 2;
        if (fk !== VD * HT * CD + 1) begin
            n_bad++;
            $display("FAIL restart_ft_clk: got %0d want %0d", fk, VD * HT * CD + 1);
        end
        if (y !== 10'(VD) || x !== 10'd0) begin
            n_bad++;
            $display("FAIL restart_ft_pos: got %0d,%0d want 0,%0d", x, y, VD);
        end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_hsync();
        test_vsync_frame();
        test_blanking();
        test_rgb_sample();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing source for the whole video path. Divides the 100 MHz system clock down to a 25 MHz pixel tick and runs the horizontal and vertical counters for 640x480@60.
- Drives the pixel coordinate bus (x, y) and video_on consumed by the pixel generator, and takes the generator's colour back.
- Emits registered hsync, vsync and blanked rgb, all aligned, to the VGA connector.

Parameters:
- CLK_DIV, 4, system clocks per pixel.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- rgb_in  in  12  colour from pixel generator for current x,y
- x  out  10  current horizontal count (h_count)
- y  out  10  current vertical count (v_count)
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
- p_tick  out  1  one-clk pulse every CLK_DIV clks
- frame_tick  out  1  one-clk pulse at start of vertical blank
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- rgb  out  12  registered, blanked colour to DAC

Behaviour:
- Derived constants: H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK=800; V_TOTAL=525.
- Reset (async, immediate) values:
  - div counter, h_count, v_count = 0.
  - p_tick = 0, frame_tick = 0, rgb = 0.
  - hsync = vsync = ~SYNC_ACTIVE (deasserted).
- Divider:
  - 2-bit count (width $clog2(CLK_DIV)), wraps at CLK_DIV-1.
  - p_tick is registered and high exactly one clk when the count wraps.
  - First p_tick occurs CLK_DIV clks after reset release; period is exactly CLK_DIV clks thereafter.
- Horizontal counter:
  - Advances only on p_tick.
  - At H_TOTAL-1 (799) it wraps to 0, and v_count advances in the same clk.
- Vertical counter:
  - Advances only when h_count wraps.
  - At V_TOTAL-1 (524) it wraps to 0.
- Counters never reach H_TOTAL or V_TOTAL.
- x, y and video_on are combinational from the counter registers, valid for the whole pixel (CLK_DIV clks). The pixel generator's 1-clk ROM latency therefore resolves within the pixel.
- Raw sync:
  - h_sync_raw is asserted when H_DISPLAY+H_FRONT <= h_count <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - v_sync_raw is asserted when v_count is 490..491.
- Output stage, updated on p_tick only; holds between ticks:
  - hsync <= h_sync_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE; vsync likewise.
  - rgb <= video_on ? rgb_in : 12'h000.
  - Fixed latency: hsync/vsync/rgb lag x/y by exactly one pixel tick (CLK_DIV clks), so colour and sync stay mutually aligned.
- rgb_in is sampled in the clk that p_tick is high, i.e. the last clk of the pixel.
- frame_tick:
  - Registered, one clk wide.
  - Asserted in the clk after the p_tick that moves the counters to h=0, v=V_DISPLAY (480).
  - Exactly once per frame, every 420000 pixel ticks.
- Wrap coincidence: at h=799, v=524 the next p_tick takes both counters to 0,0 in one clk. No extra frame_tick is generated there.
- Reset mid-frame: all state returns to reset values immediately. Counting restarts from 0,0 with no partial pulses; hsync/vsync deassert at once.
- No dependence on rgb_in content; no backpressure.

Decomposition:
- Package vga_timing_pkg holds:
  - the eight timing constants;
  - H_TOTAL, V_TOTAL;
  - the sync start/end positions;
  - RGB width (12) and the BLACK constant.
- One sub-module, pixel_tick_div (parameter CLK_DIV; ports clk, reset, p_tick), reusable by other tick-driven blocks.
- Counters, sync decode and output stage stay in vga_sync_gen.

Test Plan:
- Reset check: assert reset for 3 clks, release -> x=0, y=0, rgb=0, hsync=vsync=1, p_tick=0. First p_tick at clk 4 after release, then every 4 clks.
- Line wrap: run to h=799, v=10, wait one p_tick -> x=0, y=11 in the same clk. Check h_count never exceeds 799.
- hsync window: count p_ticks with hsync=0 per line -> exactly 96. Falling edge at the tick after h=656 is presented (one-pixel lag); rises after h=751+1.
- vsync and frame cadence:
  - vsync=0 for exactly 2 lines (1600 pixel ticks) per frame.
  - frame_tick pulses once per 420000 p_ticks, one clk wide, when y becomes 480, x=0.
- Blanking: drive rgb_in=12'hFFF constantly.
  - rgb=FFF for the pixel after x=639.
  - rgb=000 after x=640 and on all lines y>=480.
  - rgb changes only on p_tick.
- Mid-frame reset: assert reset at x=700, y=300 (inside hsync).
  - hsync returns to 1 and x,y return to 0 asynchronously.
  - After release the frame restarts cleanly, first frame_tick after 480 lines.
